// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display driver: frame-coherent snapshot, ghost gap, registered outputs.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits above digit 0.
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int GHOST_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     cs,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  e,
  output logic                  f,
  output logic                  g,
  output logic                  dp
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int GW = (GHOST_CYC > 0) ? $clog2(GHOST_CYC + 1) : 1;

  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [GW-1:0] GHOST_INIT = GW'(GHOST_CYC);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h7E;
      4'h1: hex_to_seg = 7'h30;
      4'h2: hex_to_seg = 7'h6D;
      4'h3: hex_to_seg = 7'h79;
      4'h4: hex_to_seg = 7'h33;
      4'h5: hex_to_seg = 7'h5B;
      4'h6: hex_to_seg = 7'h5F;
      4'h7: hex_to_seg = 7'h70;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h7B;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h1F;
      4'hC: hex_to_seg = 7'h4E;
      4'hD: hex_to_seg = 7'h3D;
      4'hE: hex_to_seg = 7'h4F;
      default: hex_to_seg = 7'h47;
    endcase
  endfunction

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [GW-1:0]         r_ghost;
  logic [4*DIGITS-1:0]   r_snap_data;
  logic [DIGITS-1:0]     r_snap_dp;
  logic [DIGITS-1:0]     r_cs_p1;
  logic [6:0]            r_seg_p1;
  logic                  r_dp_p1;

  logic                  w_tick;
  logic                  w_wrap;
  logic [IW+1:0]         w_nib_base;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic [DIGITS-1:0]     w_blank;

  assign w_tick     = en && (r_presc == PRESC_LAST);
  assign w_wrap     = w_tick && (r_idx == IDX_LAST);
  assign w_nib_base = {r_idx, 2'b00};
  assign w_nib      = r_snap_data[w_nib_base +: 4];
  assign w_dp_sel   = r_snap_dp[r_idx];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank only while every digit from the top down to it is a bare zero.
  always_comb begin
    logic run;
    run     = 1'b1;
    w_blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run        = run && (r_snap_data[4*i +: 4] == 4'h0) && !r_snap_dp[i];
      w_blank[i] = run;
    end
  end
`else
  assign w_blank = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_ghost     <= GHOST_INIT;
      r_snap_data <= '0;
      r_snap_dp   <= '0;
      r_cs_p1     <= '1;
      r_seg_p1    <= '0;
      r_dp_p1     <= 1'b0;
    end else begin
      if (en) begin
        if (w_tick) begin
          r_presc <= '0;
          r_idx   <= w_wrap ? '0 : r_idx + IW'(1);
          r_ghost <= GHOST_INIT;
          if (w_wrap) begin
            r_snap_data <= data;
            r_snap_dp   <= dp_in;
          end
        end else begin
          r_presc <= r_presc + PW'(1);
          if (r_ghost != '0) r_ghost <= r_ghost - GW'(1);
        end
      end

      // p1: output stage, one clock behind the scan state
      if (en && (r_ghost == '0)) begin
        r_cs_p1  <= ~(DIGITS'(1) << r_idx);
        r_seg_p1 <= w_blank[r_idx] ? 7'h00 : hex_to_seg(w_nib);
        r_dp_p1  <= w_blank[r_idx] ? 1'b0 : w_dp_sel;
      end else begin
        r_cs_p1  <= '1;
        r_seg_p1 <= '0;
        r_dp_p1  <= 1'b0;
      end
    end
  end

  assign cs              = r_cs_p1;
  assign {a,b,c,d,e,f,g} = r_seg_p1;
  assign dp              = r_dp_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4, GHOST_CYC=1.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  cs;
  logic        a, b, c, d, e, f, g, dp;
  logic [11:0] w_obs;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [11:0] DARK = 12'hF00;
  localparam logic [6:0]  S0 = 7'h7E, S1 = 7'h30, S2 = 7'h6D, S5 = 7'h5B, SA = 7'h77, SF = 7'h47;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [27:0] ZERO_FRAME = {7'h00, 7'h00, 7'h00, S0};
  localparam logic [27:0] F0050      = {7'h00, 7'h00, S5, S0};
`else
  localparam logic [27:0] ZERO_FRAME = {S0, S0, S0, S0};
  localparam logic [27:0] F0050      = {S0, S0, S5, S0};
`endif

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .GHOST_CYC(1)) dut (
    .clk(clk), .rst(rst), .en(en), .data(data), .dp_in(dp_in), .cs(cs),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp)
  );

  assign w_obs = {cs, a, b, c, d, e, f, g, dp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic slot(input string tag, input int idx, input logic [6:0] seg, input logic dpv);
    logic [3:0] csx;
    csx = ~(4'b0001 << idx);
    @(negedge clk);
    check({tag, "_gap"}, {20'h0, w_obs}, {20'h0, DARK});
    repeat (3) begin
      @(negedge clk);
      check({tag, "_lit"}, {20'h0, w_obs}, {20'h0, csx, seg, dpv});
    end
  endtask

  task automatic frame(input string tag, input logic [27:0] segs, input logic [3:0] dpm);
    for (int i = 0; i < 4; i++) slot($sformatf("%s_d%0d", tag, i), i, segs[7*i +: 7], dpm[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; data = 16'h0; dp_in = 4'h0;
    #3 rst = 1'b0;
    #1 check("rst_async", {20'h0, w_obs}, {20'h0, DARK});
    repeat (3) @(negedge clk);
    check("rst_hold", {20'h0, w_obs}, {20'h0, DARK});
    rst = 1'b1;
    data = 16'h12AF; dp_in = 4'b0100;

    frame("f0_snap0", {S0, S0, S0, S0}, 4'b0000);
    frame("f1_12AF", {S1, S2, SA, SF}, 4'b0100);

    // Mid-frame data change must not show until the next wrap
    slot("f2_d0", 0, SF, 1'b0);
    data = 16'h0000; dp_in = 4'b0000;
    slot("f2_d1", 1, SA, 1'b0);
    slot("f2_d2", 2, S2, 1'b1);
    slot("f2_d3", 3, S1, 1'b0);
    frame("f3_zero", {S0, S0, S0, S0}, 4'b0000);

    // Pause scanning in the middle of digit 2
    slot("f4_d0", 0, S0, 1'b0);
    slot("f4_d1", 1, S0, 1'b0);
    @(negedge clk); check("en_d2_gap", {20'h0, w_obs}, {20'h0, DARK});
    @(negedge clk); check("en_d2_pre", {20'h0, w_obs}, {20'h0, 4'b1011, S0, 1'b0});
    en = 1'b0;
    repeat (10) begin
      @(negedge clk); check("en_off_dark", {20'h0, w_obs}, {20'h0, DARK});
    end
    en = 1'b1;
    repeat (2) begin
      @(negedge clk); check("en_d2_post", {20'h0, w_obs}, {20'h0, 4'b1011, S0, 1'b0});
    end
    slot("f4_d3", 3, S0, 1'b0);

    data = 16'h0050;
    frame("f5_zero", ZERO_FRAME, 4'b0000);
    dp_in = 4'b1000;
    frame("f6_0050", F0050, 4'b0000);
    frame("f7_0050dp", {S0, S0, S5, S0}, 4'b1000);

    // Asynchronous reset while digit 3 is lit
    slot("f8_d0", 0, S0, 1'b0);
    slot("f8_d1", 1, S5, 1'b0);
    slot("f8_d2", 2, S0, 1'b0);
    @(negedge clk); check("f8_d3_gap", {20'h0, w_obs}, {20'h0, DARK});
    @(negedge clk); check("f8_d3_lit", {20'h0, w_obs}, {20'h0, 4'b0111, S0, 1'b1});
    #2 rst = 1'b0;
    #1 check("rst_mid_async", {20'h0, w_obs}, {20'h0, DARK});
    @(negedge clk); check("rst_mid_hold", {20'h0, w_obs}, {20'h0, DARK});
    rst = 1'b1;
    frame("f9_after_rst", ZERO_FRAME, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
